anabellek_denetleyici: RTL

Main-memory line-fill controller sitting directly downstream of the instruction cache wrapper. It accepts one 128-bit line read request at a time over the cache's `anabellek_*` handshake. It fetches the line as four 32-bit beats over a simple request/accept, data-valid memory bus, then returns the assembled line with a one-cycle ready pulse. An optional single-entry line buffer serves repeated requests for the last filled line without bus traffic.

---
 rtl/anabellek_denetleyici.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/anabellek_denetleyici.sv
// anabellek_denetleyici: main-memory line-fill controller behind the instruction cache.
// Fetches a 128-bit line as four in-order 32-bit beats over a request/accept,
// data-valid bus and returns it with a one-cycle hazir_o pulse.
// Optional feature: define ANABELLEK_SATIR_TAMPONU_EN to add a single-entry line
// buffer that answers repeat requests for the last filled line without bus traffic.
module anabellek_denetleyici (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         istek_i,
  input  logic [31:0]  adres_i,
  input  logic         oku_i,
  output logic         musait_o,
  output logic         hazir_o,
  output logic [127:0] obek_o,
  output logic         bellek_istek_o,
  output logic [31:0]  bellek_adres_o,
  input  logic         bellek_kabul_i,
  input  logic         bellek_veri_gecerli_i,
  input  logic [31:0]  bellek_veri_i
);

  typedef enum logic [1:0] {StBosta, StAdres, StVeri, StTamam} durum_e;

  durum_e         state_q, state_d;
  logic [27:0]    line_q, line_d;
  logic [1:0]     beat_q, beat_d;
  logic [127:0]   obek_q, obek_d;
  logic           musait_q, musait_d;
  logic           hazir_q, hazir_d;
  logic           bellek_istek_q, bellek_istek_d;
  logic           satir_isabet;

  // Line offset bits carry no information for a whole-line fill.
  logic           unused_adres;
  assign unused_adres = ^adres_i[3:0];

`ifdef ANABELLEK_SATIR_TAMPONU_EN
  logic [27:0]    tag_q, tag_d;
  logic           valid_q, valid_d;

  assign satir_isabet = valid_q && (tag_q == adres_i[31:4]);

  // Tag is captured on every TAMAM; on a hit the latched line already equals the tag.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    if (state_q == StTamam) begin
      tag_d   = line_q;
      valid_d = 1'b1;
    end
  end

  // Line buffer tag/valid registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end
`else
  assign satir_isabet = 1'b0;
`endif

  // Next-state, address/beat tracking and line assembly.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    beat_d  = beat_q;
    obek_d  = obek_q;
    case (state_q)
      StBosta: begin
        if (istek_i && oku_i) begin
          line_d  = adres_i[31:4];
          beat_d  = 2'd0;
          state_d = satir_isabet ? StTamam : StAdres;
        end
      end
      StAdres: begin
        if (bellek_kabul_i) begin
          state_d = StVeri;
        end
      end
      StVeri: begin
        if (bellek_veri_gecerli_i) begin
          obek_d[{beat_q, 5'd0} +: 32] = bellek_veri_i;
          if (beat_q == 2'd3) begin
            state_d = StTamam;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = StAdres;
          end
        end
      end
      StTamam: begin
        state_d = StBosta;
      end
      default: begin
        state_d = StBosta;
      end
    endcase
  end

  // Status outputs are registered images of the next state: no input-to-output paths.
  always_comb begin
    musait_d       = (state_d == StBosta);
    hazir_d        = (state_d == StTamam);
    bellek_istek_d = (state_d == StAdres);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StBosta;
      line_q         <= '0;
      beat_q         <= '0;
      obek_q         <= '0;
      musait_q       <= 1'b1;
      hazir_q        <= 1'b0;
      bellek_istek_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      line_q         <= line_d;
      beat_q         <= beat_d;
      obek_q         <= obek_d;
      musait_q       <= musait_d;
      hazir_q        <= hazir_d;
      bellek_istek_q <= bellek_istek_d;
    end
  end

  assign musait_o       = musait_q;
  assign hazir_o        = hazir_q;
  assign bellek_istek_o = bellek_istek_q;
  assign obek_o         = obek_q;
  assign bellek_adres_o = {line_q, beat_q, 2'b00};

endmodule
